// File: rtl/shift_sram_pkg.sv
// Shared types and helpers for the shift engine SRAM responder port.
package shift_sram_pkg;

    // One-hot responder states.
    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        DRAIN  = 3'b010,
        PAUSED = 3'b100
    } state_e;

    // Ceiling log2, minimum 0; sizes counters that must hold the value (n-1).
    function automatic int LOG2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Credit counter width for the default outstanding-read limit.
    localparam int MAX_OUTSTANDING_DEF = 4;
    localparam int CREDIT_W_DEF        = LOG2(MAX_OUTSTANDING_DEF + 1);

endpackage

// File: rtl/shift_sram_port_rd_pipe.sv
// Read return pipe: tracks issued reads through the SRAM latency and
// registers the returning word one stage after the SRAM presents it.
module sram_rd_pipe #(
    parameter int RD_LATENCY = 3,
    parameter int DATA_W     = 72
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [DATA_W-1:0] sram_rd_data,
    output logic              ret_next,
    output logic              busy,
    output logic              rd_shi_vld,
    output logic [DATA_W-1:0] rd_shi_data
);

    // Bit k set means a read issued k+1 cycles ago; the top bit is the strobe.
    logic [RD_LATENCY:0] vld_sr;

    // Shift issue strobes toward the output; reset discards reads in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[RD_LATENCY-1:0], issue};
        end
    end

    // Capture SRAM data in the cycle it is valid for a tracked read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_shi_data <= '0;
        end else if (vld_sr[RD_LATENCY-1]) begin
            rd_shi_data <= sram_rd_data;
        end
    end

    assign rd_shi_vld = vld_sr[RD_LATENCY];
    assign ret_next   = vld_sr[RD_LATENCY-1];
    assign busy       = |vld_sr[RD_LATENCY-1:0];

endmodule

// File: rtl/shift_sram_port.sv
// Responder end of the shift engine SRAM request protocol.
//
// Handshake: the client may pulse wr_shi_req / rd_shi_req (address and data
// valid in the same cycle) while enable is high. A request is taken only in
// IDLE with arb_grant high (and, for reads, a free credit); the matching ack
// pulses for exactly one cycle on the next clock together with the SRAM
// strobe. Anything not taken is dropped without ack and must be re-pulsed.
// A write and a read in the same cycle: the write is taken, the read dropped.
// Each acked read yields exactly one rd_shi_vld pulse, in issue order.
module shift_sram_port import shift_sram_pkg::*; #(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72,
    parameter int RD_LATENCY      = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arb_grant,
    output logic                       enable,
    input  logic                       wr_shi_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] wr_shi_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] wr_shi_data,
    output logic                       wr_shi_ack,
    input  logic                       rd_shi_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] rd_shi_addr,
    output logic                       rd_shi_ack,
    output logic [SRAM_DATA_WIDTH-1:0] rd_shi_data,
    output logic                       rd_shi_vld,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic                       sram_we,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    output logic                       sram_rd_en,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
    output logic [2:0]                 dbg_state
);

    localparam int                CRED_W   = LOG2(MAX_OUTSTANDING + 1);
    localparam logic [CRED_W-1:0] MAX_CRED = CRED_W'(MAX_OUTSTANDING);
    localparam logic [CRED_W-1:0] ONE_CRED = CRED_W'(1);

    state_e            state;
    state_e            state_nxt;
    logic [CRED_W-1:0] credits;
    logic [CRED_W-1:0] credits_nxt;
    logic              can_acc;
    logic              acc_wr;
    logic              acc_rd;
    logic              enable_nxt;
    logic              ret_next;
    logic              pipe_busy;

    // Next-state: leave IDLE on grant loss, wait out reads in DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!arb_grant) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (credits == '0 && !pipe_busy) begin
                    state_nxt = arb_grant ? IDLE : PAUSED;
                end
            end
            PAUSED: begin
                if (arb_grant) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Acceptance, credit update and the registered enable decision.
    always_comb begin
        can_acc     = (state == IDLE) && arb_grant;
        acc_wr      = can_acc && wr_shi_req;
        acc_rd      = can_acc && rd_shi_req && !wr_shi_req && (credits < MAX_CRED);
        credits_nxt = credits;
        if (acc_rd && !ret_next) begin
            credits_nxt = credits + ONE_CRED;
        end else if (!acc_rd && ret_next) begin
            credits_nxt = credits - ONE_CRED;
        end
        enable_nxt = (state_nxt == IDLE) && (credits_nxt < MAX_CRED);
    end

    // State, credits, acks and SRAM command registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            credits      <= '0;
            enable       <= 1'b0;
            wr_shi_ack   <= 1'b0;
            rd_shi_ack   <= 1'b0;
            sram_we      <= 1'b0;
            sram_rd_en   <= 1'b0;
            sram_addr    <= '0;
            sram_wr_data <= '0;
        end else begin
            state      <= state_nxt;
            credits    <= credits_nxt;
            enable     <= enable_nxt;
            wr_shi_ack <= acc_wr;
            sram_we    <= acc_wr;
            rd_shi_ack <= acc_rd;
            sram_rd_en <= acc_rd;
            if (acc_wr) begin
                sram_addr    <= wr_shi_addr;
                sram_wr_data <= wr_shi_data;
            end else if (acc_rd) begin
                sram_addr <= rd_shi_addr;
            end
        end
    end

    sram_rd_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .DATA_W     (SRAM_DATA_WIDTH)
    ) u_rd_pipe (
        .clk          (clk),
        .reset        (reset),
        .issue        (sram_rd_en),
        .sram_rd_data (sram_rd_data),
        .ret_next     (ret_next),
        .busy         (pipe_busy),
        .rd_shi_vld   (rd_shi_vld),
        .rd_shi_data  (rd_shi_data)
    );

    assign dbg_state = state;

    // A return can only arrive against a read that still holds a credit.
    credit_underflow_a: assert property (@(posedge clk) disable iff (!reset)
        ret_next |-> (credits != '0))
        else $stop;

endmodule

// File: tb/tb_shift_sram_port.sv
// Bench for shift_sram_port: random and directed request traffic against a
// pipelined SRAM model, checked cycle by cycle against a reference model.
module tb_shift_sram_port;

  localparam int AW   = 19;
  localparam int DW   = 72;
  localparam int LAT  = 3;
  localparam int MAXO = 4;
  localparam int EW   = 6 + 3 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          arb_grant = 1'b0;
  logic          wr_shi_req = 1'b0;
  logic [AW-1:0] wr_shi_addr = '0;
  logic [DW-1:0] wr_shi_data = '0;
  logic          rd_shi_req = 1'b0;
  logic [AW-1:0] rd_shi_addr = '0;
  logic          enable, wr_shi_ack, rd_shi_ack, rd_shi_vld, sram_we, sram_rd_en;
  logic [DW-1:0] rd_shi_data, sram_wr_data, sram_rd_data;
  logic [AW-1:0] sram_addr;
  logic [2:0]    dbg_state;

  shift_sram_port #(
    .SRAM_ADDR_WIDTH (AW),
    .SRAM_DATA_WIDTH (DW),
    .RD_LATENCY      (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arb_grant    (arb_grant),
    .enable       (enable),
    .wr_shi_req   (wr_shi_req),
    .wr_shi_addr  (wr_shi_addr),
    .wr_shi_data  (wr_shi_data),
    .wr_shi_ack   (wr_shi_ack),
    .rd_shi_req   (rd_shi_req),
    .rd_shi_addr  (rd_shi_addr),
    .rd_shi_ack   (rd_shi_ack),
    .rd_shi_data  (rd_shi_data),
    .rd_shi_vld   (rd_shi_vld),
    .sram_addr    (sram_addr),
    .sram_we      (sram_we),
    .sram_wr_data (sram_wr_data),
    .sram_rd_en   (sram_rd_en),
    .sram_rd_data (sram_rd_data),
    .dbg_state    (dbg_state)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [DW-1:0] init_word(input int i);
    return {8'(i), 32'h5A5A_0000 | 32'(i), 32'(i * 7 + 3)};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // ---------------- SRAM model (16 words, aliased on addr[3:0]) ----------------
  logic [DW-1:0] sram_mem [16];
  logic [DW-1:0] sram_pipe [LAT];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) sram_mem[i] <= init_word(i);
    end else if (sram_we) begin
      sram_mem[sram_addr[3:0]] <= sram_wr_data;
    end
    sram_pipe[0] <= sram_rd_en ? sram_mem[sram_addr[3:0]] : rand_word();
    for (int i = 1; i < LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
  end
  assign sram_rd_data = sram_pipe[LAT-1];

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] ret_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got=%h exp=%h", name, edge_cnt, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int            mode;          // 0 idle, 1 drain, 2 paused
  int            outstanding;
  int            ret_edges[$];
  logic [DW-1:0] ref_mem [16];
  logic [AW-1:0] ref_addr;
  logic [DW-1:0] ref_wdata;

  task automatic model_reset();
    mode = 0;
    outstanding = 0;
    ret_edges.delete();
    exp_q.delete();
    ret_q.delete();
    ref_addr = '0;
    ref_wdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic g, input logic w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra);
    int   e, old_out;
    logic ret_now, can, aw, ar, en;
    @(negedge clk);
    reset = 1'b1;
    arb_grant = g;
    wr_shi_req = w;
    wr_shi_addr = wa;
    wr_shi_data = wd;
    rd_shi_req = r;
    rd_shi_addr = ra;
    e = edge_cnt + 1;
    ret_now = (ret_edges.size() > 0) && (ret_edges[0] == e);
    if (ret_now) void'(ret_edges.pop_front());
    old_out = outstanding;
    can = (mode == 0) && g;
    aw = can && w;
    ar = can && r && !w && (outstanding < MAXO);
    if (aw) begin
      ref_mem[wa[3:0]] = wd;
      ref_addr = wa;
      ref_wdata = wd;
    end
    if (ar) begin
      ref_addr = ra;
      ret_q.push_back(ref_mem[ra[3:0]]);
      ret_edges.push_back(e + LAT + 1);
    end
    outstanding = outstanding + int'(ar) - int'(ret_now);
    case (mode)
      0: if (!g) mode = 1;
      1: if (old_out == 0) mode = g ? 0 : 2;
      default: if (g) mode = 0;
    endcase
    en = (mode == 0) && (outstanding < MAXO);
    exp_q.push_back({en, aw, aw, ar, ar, ret_now, 3'(1 << mode), ref_addr, ref_wdata});
  endtask

  task automatic idle(input int n, input logic g);
    for (int i = 0; i < n; i++) drive(g, 1'b0, AW'($urandom()), rand_word(), 1'b0, AW'($urandom()));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b1, 1'b1, a, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(1'b1, 1'b0, '0, '0, 1'b1, a);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    arb_grant = 1'b0;
    wr_shi_req = 1'b0;
    rd_shi_req = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        check("reset_outputs", 256'({enable, wr_shi_ack, sram_we, rd_shi_ack, sram_rd_en, rd_shi_vld,
                                     sram_addr, sram_wr_data, rd_shi_data}), 256'(0));
        check("reset_state", 256'(dbg_state), 256'(3'b001));
      end else begin
        if (exp_q.size() == 0) begin
          check("exp_underrun", 256'(1), 256'(0));
        end else begin
          exp_v = exp_q.pop_front();
          check("cycle", 256'({enable, wr_shi_ack, sram_we, rd_shi_ack, sram_rd_en, rd_shi_vld,
                                dbg_state, sram_addr, sram_wr_data}), 256'(exp_v));
        end
        if (rd_shi_vld) begin
          if (ret_q.size() == 0) check("ret_underrun", 256'(1), 256'(0));
          else check("rd_data", 256'(rd_shi_data), 256'(ret_q.pop_front()));
        end
      end
    end
  end

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    n_err++;
    report();
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic g;
    model_reset();
    #2 reset = 1'b0;
    repeat (4) @(posedge clk);
    idle(8, 1'b1);
    // single write then read back of the same address
    wr(19'h00005, 72'h0AB);
    idle(8, 1'b1);
    rd(19'h00005);
    idle(8, 1'b1);
    // five back-to-back reads: fifth exceeds credits
    for (int i = 0; i < 5; i++) rd(AW'(i + 1));
    idle(10, 1'b1);
    // simultaneous read and write, then read retry
    drive(1'b1, 1'b1, 19'h00010, 72'h1234, 1'b1, 19'h00011);
    idle(1, 1'b1);
    rd(19'h00011);
    idle(8, 1'b1);
    // grant loss with reads in flight, request while paused
    rd(19'h00003);
    rd(19'h00004);
    idle(6, 1'b0);
    drive(1'b0, 1'b1, 19'h00007, 72'h77, 1'b1, 19'h00008);
    idle(4, 1'b0);
    idle(3, 1'b1);
    rd(19'h00009);
    idle(8, 1'b1);
    // reset with reads in flight
    rd(19'h00001);
    rd(19'h00002);
    rd(19'h00003);
    do_reset(3);
    idle(10, 1'b1);
    // randomized traffic
    g = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) g = ~g;
      if ($urandom_range(0, 999) == 0) do_reset($urandom_range(1, 3));
      drive(g, $urandom_range(0, 3) == 0, AW'($urandom()), rand_word(),
            $urandom_range(0, 1) == 1, AW'($urandom()));
    end
    idle(20, 1'b1);
    @(posedge clk);
    #3;
    check("exp_q_empty", 256'(exp_q.size()), 256'(0));
    check("ret_q_empty", 256'(ret_q.size()), 256'(0));
    report();
    $finish;
  end

endmodule
